// File: rtl/ram_burst_master_pkg.sv
// Shared definitions for the RAM burst initiator: default widths, RAM depth
// and the controller state encoding.
package ram_burst_master_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 20;
  localparam int LEN_W_DEF  = 4;
  localparam int RAM_DEPTH  = 1024;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WR_BEAT    = 3'd1,
    ST_RD_ISSUE   = 3'd2,
    ST_RD_CAPTURE = 3'd3,
    ST_RD_HOLD    = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

endpackage

// File: rtl/ram_burst_ctr.sv
// Address / remaining-beat register pair shared by the write and read paths.
// Address arithmetic wraps modulo 2^ADDR_W.
module ram_burst_ctr #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [LEN_W-1:0]  beats_left,
  output logic              last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr   <= '0;
      beats_left <= '0;
    end else if (load) begin
      cur_addr   <= load_addr;
      beats_left <= load_len;
    end else if (step) begin
      cur_addr   <= cur_addr + ADDR_W'(1);
      beats_left <= beats_left - LEN_W'(1);
    end
  end

  assign last = (beats_left == '0);

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for the single-port program/data RAM: streams write bursts
// into the RAM and read bursts out under a valid/ready handshake.
module ram_burst_master
  import ram_burst_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_str,
  output logic              ram_ld,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done
);

  state_t            state, state_nxt;
  logic              ctr_load, ctr_step, ctr_last, capture;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  beats_left;

  ram_burst_ctr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_ctr (
    .clk        (clk),
    .rst        (rst),
    .load       (ctr_load),
    .step       (ctr_step),
    .load_addr  (req_addr),
    .load_len   (req_len),
    .cur_addr   (cur_addr),
    .beats_left (beats_left),
    .last       (ctr_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Read word is registered so it stays stable for the whole RD_HOLD wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rd_data <= '0;
    else if (capture) rd_data <= ram_rdata;
  end

  always_comb begin
    state_nxt = state;
    ctr_load  = 1'b0;
    ctr_step  = 1'b0;
    capture   = 1'b0;
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_str   = 1'b0;
    ram_ld    = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          ctr_load  = 1'b1;
          state_nxt = req_we ? ST_WR_BEAT : ST_RD_ISSUE;
        end
      end
      ST_WR_BEAT: begin
        // Strobe follows wr_valid directly so the RAM commits on the handshake edge.
        wr_ready  = 1'b1;
        ram_addr  = cur_addr;
        ram_wdata = wr_data;
        ram_str   = wr_valid;
        if (wr_valid) begin
          ctr_step = 1'b1;
          if (ctr_last) state_nxt = ST_DONE;
        end
      end
      ST_RD_ISSUE: begin
        ram_addr  = cur_addr;
        ram_ld    = 1'b1;
        state_nxt = ST_RD_CAPTURE;
      end
      ST_RD_CAPTURE: begin
        ram_addr  = cur_addr;
        ram_ld    = 1'b1;
        capture   = 1'b1;
        state_nxt = ST_RD_HOLD;
      end
      ST_RD_HOLD: begin
        rd_valid = 1'b1;
        if (rd_ready) begin
          ctr_step  = 1'b1;
          state_nxt = ctr_last ? ST_DONE : ST_RD_ISSUE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural 1024x20 RAM model.
module tb_ram_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [9:0]  req_addr;
  logic [3:0]  req_len;
  logic        wr_valid, wr_ready;
  logic [19:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [19:0] rd_data;
  logic [9:0]  ram_addr;
  logic [19:0] ram_wdata, ram_rdata;
  logic        ram_str, ram_ld, busy, done;

  int errors = 0;
  int checks = 0;
  int str_cnt = 0, ld_cnt = 0, done_cnt = 0, overlap_cnt = 0;

  logic [19:0] mem [1024];
  logic [19:0] vec [4];

  always #5 clk = ~clk;

  ram_burst_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_str(ram_str), .ram_ld(ram_ld), .ram_rdata(ram_rdata),
    .busy(busy), .done(done)
  );

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
  end

  // RAM model plus activity counters
  always @(posedge clk) begin
    if (ram_str) mem[ram_addr] <= ram_wdata;
    if (ram_ld)  ram_rdata <= mem[ram_addr];
    if (ram_str) str_cnt <= str_cnt + 1;
    if (ram_ld)  ld_cnt <= ld_cnt + 1;
    if (done)    done_cnt <= done_cnt + 1;
    if (ram_str && ram_ld) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL reset_ctrl: req_ready=%b busy=%b done=%b, want 1 0 0", req_ready, busy, done); end
    checks++;
    if (ram_str !== 1'b0 || ram_ld !== 1'b0 || rd_valid !== 1'b0 || wr_ready !== 1'b0)
      begin errors++; $display("FAIL reset_strobes: str=%b ld=%b rd_valid=%b wr_ready=%b, want 0", ram_str, ram_ld, rd_valid, wr_ready); end
    checks++;
    if (rd_data !== 20'd0 || ram_addr !== 10'd0)
      begin errors++; $display("FAIL reset_data: rd_data=%0d ram_addr=%0d, want 0 0", rd_data, ram_addr); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_burst(input logic [9:0] addr, input logic [3:0] len,
                             input int gap_before, input int gap_cyc, input string name);
    int n = int'(len) + 1;
    int s0 = str_cnt;
    int d0 = done_cnt;
    logic [9:0] a = addr;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_len = len;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == gap_before) begin
        wr_valid = 1'b0;
        for (int g = 0; g < gap_cyc; g++) begin
          #1;
          checks++;
          if (ram_str !== 1'b0 || ram_addr !== a)
            begin errors++; $display("FAIL %s_gap: str=%b addr=%0d, want 0 %0d", name, ram_str, ram_addr, a); end
          @(negedge clk);
        end
      end
      wr_valid = 1'b1; wr_data = vec[i];
      #1;
      checks++;
      if (ram_str !== 1'b1 || ram_addr !== a || ram_wdata !== vec[i])
        begin errors++; $display("FAIL %s_beat%0d: str=%b addr=%0d wdata=%0d, want 1 %0d %0d", name, i, ram_str, ram_addr, ram_wdata, a, vec[i]); end
      a = a + 10'd1;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1)
      begin errors++; $display("FAIL %s_done: done=%b busy=%b, want 1 1", name, done, busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0)
      begin errors++; $display("FAIL %s_idle: busy=%b req_ready=%b done=%b, want 0 1 0", name, busy, req_ready, done); end
    checks++;
    if (str_cnt - s0 !== n || done_cnt - d0 !== 1)
      begin errors++; $display("FAIL %s_counts: strobes=%0d dones=%0d, want %0d 1", name, str_cnt - s0, done_cnt - d0, n); end
    a = addr;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (mem[a] !== vec[i])
        begin errors++; $display("FAIL %s_mem[%0d]: got %0d, want %0d", name, a, mem[a], vec[i]); end
      a = a + 10'd1;
    end
  endtask

  task automatic read_burst(input logic [9:0] addr, input logic [3:0] len,
                            input int hold_beat, input int hold_cyc, input bit poke_req,
                            input string name);
    int n = int'(len) + 1;
    int k = 0;
    int budget = 0;
    int l0 = ld_cnt;
    int d0 = done_cnt;
    bit poked = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_len = len; rd_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    while (k < n && budget < 200) begin
      if (rd_valid) begin
        if (poke_req && !poked) begin
          req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd100; req_len = 4'd15;
          poked = 1'b1;
          #1;
          checks++;
          if (req_ready !== 1'b0)
            begin errors++; $display("FAIL %s_req_ready_busy: got %b, want 0", name, req_ready); end
        end
        if (k == hold_beat) begin
          rd_ready = 1'b0;
          for (int h = 0; h < hold_cyc; h++) begin
            @(negedge clk);
            req_valid = 1'b0;
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== vec[k])
              begin errors++; $display("FAIL %s_hold%0d: rd_valid=%b rd_data=%0d, want 1 %0d", name, h, rd_valid, rd_data, vec[k]); end
          end
          rd_ready = 1'b1;
        end
        checks++;
        if (rd_data !== vec[k])
          begin errors++; $display("FAIL %s_beat%0d: rd_data=%0d, want %0d", name, k, rd_data, vec[k]); end
        k++;
      end
      @(negedge clk);
      req_valid = 1'b0;
      budget++;
    end
    if (k < n) begin
      errors++; checks++;
      $display("FAIL %s_timeout: beats=%0d, want %0d", name, k, n);
    end
    #1;
    checks++;
    if (done !== 1'b1 || rd_valid !== 1'b0)
      begin errors++; $display("FAIL %s_done: done=%b rd_valid=%b, want 1 0", name, done, rd_valid); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1)
      begin errors++; $display("FAIL %s_idle: busy=%b req_ready=%b, want 0 1", name, busy, req_ready); end
    checks++;
    if (ld_cnt - l0 !== 2 * n || done_cnt - d0 !== 1)
      begin errors++; $display("FAIL %s_counts: ld_cycles=%0d dones=%0d, want %0d 1", name, ld_cnt - l0, done_cnt - d0, 2 * n); end
  endtask

  task automatic test_write_burst();
    vec[0] = 20'd101; vec[1] = 20'd202; vec[2] = 20'd303; vec[3] = 20'd404;
    write_burst(10'd0, 4'd3, -1, 0, "wr0");
  endtask

  task automatic test_read_backpressure();
    vec[0] = 20'd101; vec[1] = 20'd202; vec[2] = 20'd303; vec[3] = 20'd404;
    read_burst(10'd0, 4'd3, 2, 3, 1'b0, "rd0");
  endtask

  task automatic test_wrap();
    vec[0] = 20'd1; vec[1] = 20'd2; vec[2] = 20'd3; vec[3] = 20'd4;
    write_burst(10'd1022, 4'd3, -1, 0, "wrwrap");
    read_burst(10'd1022, 4'd3, -1, 0, 1'b0, "rdwrap");
  endtask

  task automatic test_write_gap();
    vec[0] = 20'd11; vec[1] = 20'd22; vec[2] = 20'd33; vec[3] = 20'd0;
    write_burst(10'd8, 4'd2, 2, 2, "wrgap");
  endtask

  task automatic test_req_ignored();
    vec[0] = 20'd11; vec[1] = 20'd22; vec[2] = 20'd33; vec[3] = 20'd0;
    read_burst(10'd8, 4'd2, -1, 0, 1'b1, "rdpoke");
    checks++;
    if (mem[100] !== 20'd0)
      begin errors++; $display("FAIL poke_mem100: got %0d, want 0", mem[100]); end
  endtask

  task automatic test_reset_mid_write();
    int s0 = str_cnt;
    int d0 = done_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd4; req_len = 4'd3;
    @(negedge clk);
    req_valid = 1'b0;
    wr_valid = 1'b1; wr_data = 20'd505;
    @(negedge clk);
    wr_data = 20'd606;
    @(negedge clk);
    wr_data = 20'd707;
    #1;
    checks++;
    if (ram_str !== 1'b1 || ram_addr !== 10'd6)
      begin errors++; $display("FAIL rstmid_pre: str=%b addr=%0d, want 1 6", ram_str, ram_addr); end
    rst = 1'b1;
    #1;
    checks++;
    if (ram_str !== 1'b0 || ram_ld !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL rstmid_async: str=%b ld=%b req_ready=%b busy=%b done=%b, want 0 0 1 0 0", ram_str, ram_ld, req_ready, busy, done); end
    @(negedge clk);
    rst = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem[4] !== 20'd505 || mem[5] !== 20'd606 || mem[6] !== 20'd0 || mem[7] !== 20'd0)
      begin errors++; $display("FAIL rstmid_mem: %0d %0d %0d %0d, want 505 606 0 0", mem[4], mem[5], mem[6], mem[7]); end
    checks++;
    if (str_cnt - s0 !== 2 || done_cnt - d0 !== 0)
      begin errors++; $display("FAIL rstmid_counts: strobes=%0d dones=%0d, want 2 0", str_cnt - s0, done_cnt - d0); end
  endtask

  task automatic test_no_overlap();
    checks++;
    if (overlap_cnt !== 0)
      begin errors++; $display("FAIL str_ld_overlap: cycles=%0d, want 0", overlap_cnt); end
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    test_reset();
    test_write_burst();
    test_read_backpressure();
    test_wrap();
    test_write_gap();
    test_req_ignored();
    test_reset_mid_write();
    test_no_overlap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
